// File: rtl/fix_parser_pkg.sv
// Shared constants, lexer state type and byte-class helper for the FIX tag/value lexer.
package fix_parser_pkg;

    localparam logic [7:0]  ASCII_SOH    = 8'h01;
    localparam logic [7:0]  ASCII_EQ     = 8'h3D;
    localparam logic [7:0]  ASCII_0      = 8'h30;
    localparam logic [7:0]  ASCII_9      = 8'h39;
    localparam logic [15:0] TAG_CHECKSUM = 16'h3130;

    typedef enum logic [2:0] {
        S_TAG      = 3'd0,
        S_VALUE    = 3'd1,
        S_EMIT_TAG = 3'd2,
        S_GAP1     = 3'd3,
        S_EMIT_VAL = 3'd4,
        S_GAP2     = 3'd5,
        S_SYNC     = 3'd6
    } lexer_state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/fix_checksum_acc.sv
// Running FIX checksum, per-field snapshot and decimal parse of the tag-10 value.
module fix_checksum_acc
    import fix_parser_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_i,
    input  logic       add_i,
    input  logic       commit_i,
    input  logic       dec_i,
    input  logic       clear_i,
    output logic       err_o
);

    logic [7:0] sum_q;
    logic [7:0] snap_q;
    logic [9:0] dec_q;
    logic [5:0] dec_cnt_q;
    logic       dec_bad_q;
    logic [9:0] dec_next;

    assign dec_next = 10'(dec_q * 10'd10) + {6'b0, byte_i[3:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q     <= '0;
            snap_q    <= '0;
            dec_q     <= '0;
            dec_cnt_q <= '0;
            dec_bad_q <= 1'b0;
        end else if (clear_i) begin
            sum_q     <= '0;
            snap_q    <= '0;
            dec_q     <= '0;
            dec_cnt_q <= '0;
            dec_bad_q <= 1'b0;
        end else begin
            if (add_i)
                sum_q <= sum_q + byte_i;
            // Snapshot includes the field-terminating SOH presented this cycle
            if (commit_i)
                snap_q <= sum_q + byte_i;
            if (dec_i) begin
                if (is_digit(byte_i))
                    dec_q <= dec_next;
                else
                    dec_bad_q <= 1'b1;
                if (dec_cnt_q != '1)
                    dec_cnt_q <= dec_cnt_q + 6'd1;
            end
        end
    end

    assign err_o = dec_bad_q || (dec_cnt_q != 6'd3) || (dec_q != {2'b00, snap_q});

endmodule

// File: rtl/fix_parser_lexer.sv
// Splits a raw FIX byte stream into tag and value bursts and validates the tag-10 checksum.
module fix_parser_lexer
    import fix_parser_pkg::*;
#(
    parameter int unsigned MAX_TAG_BYTES = 4,
    parameter int unsigned MAX_VAL_BYTES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_i,
    input  logic       byte_valid_i,
    output logic       ready_o,
    output logic [7:0] data_o,
    output logic       start_tag_o,
    output logic       start_value_o,
    output logic       checksum_valid_o,
    output logic       checksum_err_o,
    output logic       frame_err_o
);

    localparam int unsigned TCW = $clog2(MAX_TAG_BYTES + 1);
    localparam int unsigned VCW = $clog2(MAX_VAL_BYTES + 1);
    localparam int unsigned TIW = (MAX_TAG_BYTES > 1) ? $clog2(MAX_TAG_BYTES) : 1;
    localparam int unsigned VIW = (MAX_VAL_BYTES > 1) ? $clog2(MAX_VAL_BYTES) : 1;
    localparam logic [TCW-1:0] TAG_MAX = TCW'(MAX_TAG_BYTES);
    localparam logic [VCW-1:0] VAL_MAX = VCW'(MAX_VAL_BYTES);

    lexer_state_t   state_q, state_d;
    logic [TCW-1:0] tag_cnt_q, tag_cnt_d;
    logic [VCW-1:0] val_cnt_q, val_cnt_d;
    logic [VCW-1:0] idx_q, idx_d;
    logic           sync_exit_q, sync_exit_d;
    logic           ferr_q, ferr_d;
    logic           cvld_q, cvld_d;
    logic           cerr_q, cerr_d;
    logic [7:0]     tag_buf_q [MAX_TAG_BYTES];
    logic [7:0]     val_buf_q [MAX_VAL_BYTES];

    logic accept, is_dig, is_eq, is_soh, is_cs, err;
    logic tag_we, val_we;
    logic cs_add, cs_commit, cs_dec, cs_clear, cs_err;

    assign ready_o = rst && ((state_q == S_TAG) || (state_q == S_VALUE) || (state_q == S_SYNC));
    assign accept  = byte_valid_i && ready_o;
    assign is_dig  = is_digit(byte_i);
    assign is_eq   = (byte_i == ASCII_EQ);
    assign is_soh  = (byte_i == ASCII_SOH);
    assign is_cs   = (tag_cnt_q == TCW'(2)) && ({tag_buf_q[0], tag_buf_q[1]} == TAG_CHECKSUM);

    fix_checksum_acc u_checksum (
        .clk      (clk),
        .rst      (rst),
        .byte_i   (byte_i),
        .add_i    (cs_add),
        .commit_i (cs_commit),
        .dec_i    (cs_dec),
        .clear_i  (cs_clear),
        .err_o    (cs_err)
    );

    always_comb begin
        state_d     = state_q;
        tag_cnt_d   = tag_cnt_q;
        val_cnt_d   = val_cnt_q;
        idx_d       = idx_q;
        sync_exit_d = sync_exit_q;
        ferr_d      = 1'b0;
        cvld_d      = 1'b0;
        cerr_d      = 1'b0;
        tag_we      = 1'b0;
        val_we      = 1'b0;
        err         = 1'b0;
        cs_add      = 1'b0;
        cs_commit   = 1'b0;
        cs_dec      = 1'b0;
        cs_clear    = 1'b0;
        case (state_q)
            S_TAG: if (accept) begin
                cs_add = 1'b1;
                if (is_dig && (tag_cnt_q < TAG_MAX)) begin
                    tag_we    = 1'b1;
                    tag_cnt_d = tag_cnt_q + TCW'(1);
                end else if (is_eq && (tag_cnt_q != '0)) begin
                    state_d = S_VALUE;
                end else begin
                    err = 1'b1;
                end
            end
            S_VALUE: if (accept) begin
                if (is_soh) begin
                    if (val_cnt_q == '0) begin
                        err = 1'b1;
                    end else begin
                        state_d = S_EMIT_TAG;
                        idx_d   = '0;
                        if (is_cs) begin
                            cvld_d   = 1'b1;
                            cerr_d   = cs_err;
                            cs_clear = 1'b1;
                        end else begin
                            cs_add    = 1'b1;
                            cs_commit = 1'b1;
                        end
                    end
                end else if (val_cnt_q < VAL_MAX) begin
                    val_we    = 1'b1;
                    val_cnt_d = val_cnt_q + VCW'(1);
                    // Checksum digits are parsed, not summed
                    if (is_cs)
                        cs_dec = 1'b1;
                    else
                        cs_add = 1'b1;
                end else begin
                    err = 1'b1;
                end
            end
            S_EMIT_TAG: begin
                if ((idx_q + VCW'(1)) == VCW'(tag_cnt_q)) begin
                    state_d = S_GAP1;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + VCW'(1);
                end
            end
            S_GAP1: state_d = S_EMIT_VAL;
            S_EMIT_VAL: begin
                if ((idx_q + VCW'(1)) == val_cnt_q) begin
                    state_d = S_GAP2;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + VCW'(1);
                end
            end
            S_GAP2: begin
                state_d   = S_TAG;
                tag_cnt_d = '0;
                val_cnt_d = '0;
            end
            S_SYNC: begin
                cs_add = accept;
                if (sync_exit_q || (accept && is_soh)) begin
                    state_d     = S_TAG;
                    sync_exit_d = 1'b0;
                end
            end
            default: state_d = S_TAG;
        endcase
        // An SOH that is itself the bad byte already marks the next field boundary
        if (err) begin
            state_d     = S_SYNC;
            ferr_d      = 1'b1;
            cs_clear    = 1'b1;
            tag_cnt_d   = '0;
            val_cnt_d   = '0;
            sync_exit_d = is_soh;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_TAG;
            tag_cnt_q   <= '0;
            val_cnt_q   <= '0;
            idx_q       <= '0;
            sync_exit_q <= 1'b0;
            ferr_q      <= 1'b0;
            cvld_q      <= 1'b0;
            cerr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tag_cnt_q   <= tag_cnt_d;
            val_cnt_q   <= val_cnt_d;
            idx_q       <= idx_d;
            sync_exit_q <= sync_exit_d;
            ferr_q      <= ferr_d;
            cvld_q      <= cvld_d;
            cerr_q      <= cerr_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < MAX_TAG_BYTES; i++)
                tag_buf_q[i] <= '0;
            for (int unsigned i = 0; i < MAX_VAL_BYTES; i++)
                val_buf_q[i] <= '0;
        end else begin
            if (tag_we)
                tag_buf_q[tag_cnt_q[TIW-1:0]] <= byte_i;
            if (val_we)
                val_buf_q[val_cnt_q[VIW-1:0]] <= byte_i;
        end
    end

    always_comb begin
        data_o = '0;
        case (state_q)
            S_EMIT_TAG: data_o = tag_buf_q[idx_q[TIW-1:0]];
            S_EMIT_VAL: data_o = val_buf_q[idx_q[VIW-1:0]];
            default:    data_o = '0;
        endcase
    end

    assign start_tag_o      = (state_q == S_EMIT_TAG);
    assign start_value_o    = (state_q == S_EMIT_VAL);
    assign checksum_valid_o = cvld_q;
    assign checksum_err_o   = cerr_q;
    assign frame_err_o      = ferr_q;

endmodule

// File: tb/tb_fix_parser_lexer.sv
// Directed bench for fix_parser_lexer: emitted bursts, checksum, framing errors and reset.
module tb_fix_parser_lexer;
    import fix_parser_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] byte_i;
    logic       byte_valid_i;
    logic       ready_o;
    logic [7:0] data_o;
    logic       start_tag_o;
    logic       start_value_o;
    logic       checksum_valid_o;
    logic       checksum_err_o;
    logic       frame_err_o;

    always #5 clk = ~clk;

    fix_parser_lexer #(
        .MAX_TAG_BYTES (4),
        .MAX_VAL_BYTES (32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .byte_i           (byte_i),
        .byte_valid_i     (byte_valid_i),
        .ready_o          (ready_o),
        .data_o           (data_o),
        .start_tag_o      (start_tag_o),
        .start_value_o    (start_value_o),
        .checksum_valid_o (checksum_valid_o),
        .checksum_err_o   (checksum_err_o),
        .frame_err_o      (frame_err_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] tag_q [$];
    logic [7:0] val_q [$];
    int         cs_err_q [$];
    int         cs_at_tag_q [$];
    int         runs_q [$];
    int         tag_bursts = 0, val_bursts = 0, ferr_cnt = 0;
    int         overlap_cnt = 0, dz_cnt = 0, run = 0;
    logic       prev_tag = 1'b0, prev_val = 1'b0;

    always @(negedge clk) begin
        if (start_tag_o) tag_q.push_back(data_o);
        if (start_value_o) val_q.push_back(data_o);
        if (start_tag_o && !prev_tag) tag_bursts++;
        if (start_value_o && !prev_val) val_bursts++;
        if (checksum_valid_o) begin
            cs_err_q.push_back(int'(checksum_err_o));
            cs_at_tag_q.push_back(int'(start_tag_o && !prev_tag));
        end
        if (frame_err_o) ferr_cnt++;
        if (start_tag_o && start_value_o) overlap_cnt++;
        if (!start_tag_o && !start_value_o && data_o != 8'h00) dz_cnt++;
        if (!ready_o && rst) begin
            run++;
        end else begin
            if (run > 0) runs_q.push_back(run);
            run = 0;
        end
        prev_tag = start_tag_o;
        prev_val = start_value_o;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        byte_i       = b;
        byte_valid_i = 1'b1;
        while (!ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("send_ready", int'(ready_o), 1);
        if (ready_o) @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            byte_valid_i = 1'b0;
        end
    endtask

    task automatic send_str(input string s, input bit gap);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            if (gap) idle(1);
        end
    endtask

    task automatic send_field(input string s, input bit gap);
        send_str(s, gap);
        send_byte(ASCII_SOH);
        if (gap) idle(1);
    endtask

    int tb0, vb0, fb0, cb0, rb0, tbu0, vbu0;

    task automatic mark();
        tb0  = tag_q.size();
        vb0  = val_q.size();
        fb0  = ferr_cnt;
        cb0  = cs_err_q.size();
        rb0  = runs_q.size();
        tbu0 = tag_bursts;
        vbu0 = val_bursts;
    endtask

    task automatic expect_emit(input string name, input string t, input string v);
        check_eq({name, "_tag_len"}, tag_q.size() - tb0, t.len());
        for (int i = 0; i < t.len(); i++)
            if (tb0 + i < tag_q.size()) check_eq({name, "_tag_byte"}, int'(tag_q[tb0 + i]), int'(t[i]));
        check_eq({name, "_val_len"}, val_q.size() - vb0, v.len());
        for (int i = 0; i < v.len(); i++)
            if (vb0 + i < val_q.size()) check_eq({name, "_val_byte"}, int'(val_q[vb0 + i]), int'(v[i]));
    endtask

    string long_val;
    int    n;

    initial begin
        rst          = 1'b0;
        byte_i       = 8'h00;
        byte_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", int'(ready_o), 0);
        check_eq("rst_data", int'(data_o), 0);
        check_eq("rst_strobes", int'({start_tag_o, start_value_o, checksum_valid_o, checksum_err_o, frame_err_o}), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("rel_ready", int'(ready_o), 1);

        // Checksum good, then bad value, then non-digit in value
        mark();
        send_field("8=A", 1'b0);
        send_field("10=183", 1'b0);
        idle(45);
        expect_emit("cs_ok", "810", "A183");
        check_eq("cs_ok_pulses", cs_err_q.size() - cb0, 1);
        if (cs_err_q.size() > cb0) begin
            check_eq("cs_ok_err", cs_err_q[cb0], 0);
            check_eq("cs_ok_with_tag", cs_at_tag_q[cb0], 1);
        end
        mark();
        send_field("8=A", 1'b0);
        send_field("10=184", 1'b0);
        idle(45);
        check_eq("cs_bad_pulses", cs_err_q.size() - cb0, 1);
        if (cs_err_q.size() > cb0) check_eq("cs_bad_err", cs_err_q[cb0], 1);
        mark();
        send_field("8=A", 1'b0);
        send_field("10=1X3", 1'b0);
        idle(45);
        check_eq("cs_nd_pulses", cs_err_q.size() - cb0, 1);
        if (cs_err_q.size() > cb0) check_eq("cs_nd_err", cs_err_q[cb0], 1);

        // Basic field at one byte per cycle
        mark();
        send_field("8=FIX.4.2", 1'b0);
        idle(45);
        expect_emit("basic", "8", "FIX.4.2");
        check_eq("basic_tag_bursts", tag_bursts - tbu0, 1);
        check_eq("basic_val_bursts", val_bursts - vbu0, 1);
        check_eq("basic_busy_runs", runs_q.size() - rb0, 1);
        if (runs_q.size() > rb0) check_eq("basic_busy_len", runs_q[rb0], 10);
        check_eq("basic_no_ferr", ferr_cnt - fb0, 0);
        check_eq("basic_no_cs", cs_err_q.size() - cb0, 0);

        // Fifth tag digit is a framing error; next field parses
        mark();
        send_str("1234", 1'b0);
        send_byte("5");
        #1 check_eq("tag5_ferr_pulse", int'(frame_err_o), 1);
        send_str("=X", 1'b0);
        send_byte(ASCII_SOH);
        send_field("35=D", 1'b0);
        idle(45);
        check_eq("tag5_ferr_cnt", ferr_cnt - fb0, 1);
        expect_emit("tag5", "35", "D");

        // 33-byte value errors; 32-byte value emits contiguously
        mark();
        send_str("1=", 1'b0);
        for (int i = 0; i < 33; i++) send_byte("A");
        #1 check_eq("v33_ferr_pulse", int'(frame_err_o), 1);
        send_byte(ASCII_SOH);
        long_val = "";
        for (int i = 0; i < 32; i++) long_val = {long_val, $sformatf("%c", 8'h40 + i)};
        send_field({"2=", long_val}, 1'b0);
        idle(50);
        check_eq("v33_ferr_cnt", ferr_cnt - fb0, 1);
        expect_emit("v32", "2", long_val);
        check_eq("v32_val_bursts", val_bursts - vbu0, 1);

        // Gapped input, then 4-digit tag boundary
        mark();
        send_field("49=AB", 1'b1);
        idle(45);
        expect_emit("gap", "49", "AB");
        check_eq("gap_tag_bursts", tag_bursts - tbu0, 1);
        check_eq("gap_val_bursts", val_bursts - vbu0, 1);
        mark();
        send_field("1234=V", 1'b0);
        idle(45);
        expect_emit("tag4", "1234", "V");

        // Empty value and empty tag errors
        mark();
        send_field("3=", 1'b0);
        idle(3);
        send_str("=5", 1'b0);
        send_byte(ASCII_SOH);
        send_field("4=Z", 1'b0);
        idle(45);
        check_eq("empty_ferr_cnt", ferr_cnt - fb0, 2);
        expect_emit("empty", "4", "Z");

        // Reset during value emission
        send_field("5=ABCDEF", 1'b0);
        n = 0;
        @(negedge clk);
        byte_valid_i = 1'b0;
        while (!start_value_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("mid_reached_value", int'(start_value_o), 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_ready", int'(ready_o), 0);
        check_eq("mid_rst_data", int'(data_o), 0);
        check_eq("mid_rst_strobes", int'({start_tag_o, start_value_o, checksum_valid_o, frame_err_o}), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_rel_ready", int'(ready_o), 1);
        mark();
        send_field("7=Q", 1'b0);
        idle(45);
        expect_emit("after_rst", "7", "Q");

        check_eq("no_overlap", overlap_cnt, 0);
        check_eq("idle_data_zero", dz_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fix_parser_lexer.md
FIX_PARSER_LEXER -- requirements
Module: fix_parser_lexer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clock port `clk`, reset port `rst` (rst=0 resets).
REQ-002 Parameter: MAX_TAG_BYTES, 4, maximum tag digits per field.
REQ-003 Parameter: MAX_VAL_BYTES, 32, maximum value bytes per field (matches the 256-bit downstream value).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 byte_i  input  8  raw FIX byte stream.
REQ-007 byte_valid_i  input  1  byte_i valid; a byte is accepted when byte_valid_i && ready_o.
REQ-008 ready_o  output  1  block can accept a byte this cycle.
REQ-009 data_o  output  8  tag/value byte to the tag/value extraction stage.
REQ-010 start_tag_o  output  1  data_o is a tag byte.
REQ-011 start_value_o  output  1  data_o is a value byte.
REQ-012 checksum_valid_o  output  1  one-cycle pulse: a tag-10 field completed.
REQ-013 checksum_err_o  output  1  qualified by checksum_valid_o: received checksum != computed checksum.
REQ-014 frame_err_o  output  1  one-cycle pulse: malformed field discarded.

Function
REQ-015 States SHALL be: S_TAG, S_VALUE, S_EMIT_TAG, S_GAP1, S_EMIT_VAL, S_GAP2, S_SYNC.
REQ-016 ready_o SHALL be 1 in S_TAG, S_VALUE and S_SYNC, and 0 otherwise; it is decoded from state only.
REQ-017 S_TAG behaviour:
- accepted ASCII digit (0x30-0x39): stored in tag buffer; tag count increments.
- accepted '=' (0x3D) with 1..MAX_TAG_BYTES digits: go to S_VALUE.
REQ-018 S_VALUE behaviour:
- accepted byte other than SOH (0x01): stored; value count increments.
- accepted SOH with 1..MAX_VAL_BYTES bytes: go to S_EMIT_TAG on the next cycle.
REQ-019 Any of the following SHALL pulse frame_err_o the cycle after the offending byte is accepted, discard the field, and go to S_SYNC:
- non-digit in S_TAG;
- '=' with zero digits;
- a digit beyond MAX_TAG_BYTES;
- SOH in S_TAG;
- SOH with zero value bytes;
- a byte beyond MAX_VAL_BYTES.
REQ-020 S_SYNC SHALL drop bytes until an accepted SOH, then enter S_TAG with cleared counts; an SOH that caused the error itself also exits S_SYNC next cycle.
REQ-021 Emission sequence:
- S_EMIT_TAG: start_tag_o=1 for exactly N cycles (N = tag count), data_o = tag bytes in arrival order, first byte the cycle after SOH acceptance.
- S_GAP1: one cycle, both strobes 0.
- S_EMIT_VAL: start_value_o=1 for exactly M contiguous cycles, arrival order.
- S_GAP2: one cycle.
- Then S_TAG.
REQ-022 Emitted bursts SHALL be contiguous regardless of byte_valid_i gaps during collection; '=' and SOH are never emitted.
REQ-023 When both strobes are 0, data_o SHALL be 0; strobes are never 1 simultaneously.
REQ-024 Running checksum rules:
- 8-bit running sum (mod 256) of every accepted byte, SOH included;
- committed to a snapshot at each valid field SOH;
- sum and snapshot clear after a tag-10 field completes or a frame error occurs.
REQ-025 A field whose tag is exactly "10" SHALL have its value bytes excluded from the running sum and parsed as decimal (acc = acc*10 + digit, 10-bit).
REQ-026 On the tag-10 field's SOH, checksum_valid_o SHALL pulse for one cycle, concurrent with the first start_tag_o cycle.
REQ-027 checksum_err_o SHALL be 1 in that same cycle if any of the following holds: value not 3 digits, a non-digit, or acc != snapshot.
REQ-028 Simultaneous frame error and checksum completion cannot occur; frame error takes precedence and suppresses checksum_valid_o.

Reset
REQ-029 rst=0 SHALL asynchronously force:
- state S_TAG;
- all counts, buffers, sum and snapshot to 0;
- ready_o=0, data_o=0, all strobes and pulses 0.
REQ-030 Reset mid-emission SHALL abort the burst immediately; after release ready_o=1 on the first clock edge.

Structure
REQ-031 Package fix_parser_pkg SHALL hold:
- constants ASCII_SOH=8'h01, ASCII_EQ=8'h3D, ASCII_0=8'h30, ASCII_9=8'h39;
- TAG_CHECKSUM=16'h3130;
- the lexer state enum typedef.
REQ-032 Sub-module fix_checksum_acc SHALL own the running sum, snapshot, decimal accumulator and compare.

Verification
REQ-033 Input "8=FIX.4.2<SOH>" at one byte/cycle -> start_tag_o one cycle data 0x38, one gap, start_value_o 7 cycles 46 49 58 2E 34 2E 32, one gap, ready_o 0 for 10 cycles.
REQ-034 Input "8=A<SOH>10=183<SOH>" -> checksum_valid_o=1, checksum_err_o=0 (0x38+0x3D+0x41+0x01=183); repeat with "10=184" -> checksum_err_o=1.
REQ-035 Input "12345=X<SOH>35=D<SOH>" -> frame_err_o pulse after '5', nothing emitted for that field, then field 35/"D" emitted normally.
REQ-036 Value of 33 bytes -> frame_err_o after 33rd byte; resync at SOH; 32-byte value -> emitted as 32 contiguous start_value_o cycles.
REQ-037 "49=AB<SOH>" with byte_valid_i toggling every other cycle -> tag 34 39 and value 41 42 emitted contiguously.
REQ-038 rst low during S_EMIT_VAL -> all outputs 0 immediately; after release, ready_o=1 and the next field parses correctly.
